// File: rtl/modmul_q_pkg.sv
// ----------------------------------------------------------------------------
// modmul_q_pkg
//   Shared types and sizing for the ModMul issue queue slice.
//   WIDTH  : operand/result width
//   TAG_W  : width of the opaque caller tag
//   DEPTH  : FIFO entries (power of 2, >= 2), not counting the in-flight op
//   P      : prime modulus, must match the downstream ModMul instance
//   PTR_W  : FIFO index width
// ----------------------------------------------------------------------------
package modmul_q_pkg;

    localparam int WIDTH = 128;
    localparam int TAG_W = 4;
    localparam int DEPTH = 4;
    localparam logic [WIDTH-1:0] P = 128'd37;
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [TAG_W-1:0] tag;
    } entry_t;

endpackage

// File: rtl/modmul_q_fifo.sv
// ----------------------------------------------------------------------------
// modmul_q_fifo
//   Synchronous FIFO of operand entries. Pointers carry one extra wrap bit so
//   full and empty are told apart without a separate occupancy counter.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (empties the FIFO)
//   push       write push_data when not full
//   push_data  entry to enqueue
//   pop        drop the head entry when not empty
//   pop_data   head entry (valid while !empty)
//   full       DEPTH entries stored
//   empty      no entries stored
// ----------------------------------------------------------------------------
module modmul_q_fifo
    import modmul_q_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    entry_t           mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign pop_data = mem[rd_ptr[PTR_W-1:0]];

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/modmul_issue_queue.sv
// ----------------------------------------------------------------------------
// modmul_issue_queue
//   Upstream feeder for the ModMul engine. Buffers (a, b, tag) operand pairs,
//   issues them one at a time over ModMul's enable/done interface and returns
//   each result with its tag on a valid/ready output, in issue order.
// Optional feature macro: MODMUL_Q_RANGE_CHECK_EN
//   When defined, pairs with a >= P or b >= P are consumed but dropped, and
//   err_range pulses for one cycle after such a push.
// Ports:
//   clk, reset              clock / asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_ready = !fifo_full)
//   in_a, in_b, in_tag      operand pair and caller tag
//   mm_a, mm_b, mm_enable   registered operands and enable to ModMul
//   mm_r, mm_done           ModMul result and completion
//   out_valid/out_ready     result handshake
//   out_r, out_tag          result (mm_r verbatim) and its tag
//   busy                    FIFO non-empty or an operation in progress
//   err_range               range-check pulse (macro builds only)
// ----------------------------------------------------------------------------
module modmul_issue_queue
    import modmul_q_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] mm_a,
    output logic [WIDTH-1:0] mm_b,
    output logic             mm_enable,
    input  logic [WIDTH-1:0] mm_r,
    input  logic             mm_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef MODMUL_Q_RANGE_CHECK_EN
    ,
    output logic             err_range
`endif
);

    state_t           state;
    logic [TAG_W-1:0] tag_q;
    entry_t           push_entry;
    entry_t           head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             push_fire;

    // in_ready looks only at full, so a same-cycle pop never frees a slot.
    assign in_ready   = !fifo_full;
    assign push_fire  = in_valid && in_ready;
    assign push_entry = '{a: in_a, b: in_b, tag: in_tag};
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign busy       = !fifo_empty || (state != IDLE);

`ifdef MODMUL_Q_RANGE_CHECK_EN
    logic range_bad;

    assign range_bad = (in_a >= P) || (in_b >= P);
    assign fifo_push = push_fire && !range_bad;

    // Out-of-range pairs complete their handshake but are only flagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_range <= 1'b0;
        end else begin
            err_range <= push_fire && range_bad;
        end
    end
`else
    assign fifo_push = push_fire;
`endif

    modmul_q_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Issue FSM. The IDLE state always lasts at least one cycle after a
    // result handshake, so mm_enable drops before the next issue and ModMul
    // always sees a fresh rising edge. mm_done/mm_r are only looked at in RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mm_a      <= '0;
            mm_b      <= '0;
            tag_q     <= '0;
            mm_enable <= 1'b0;
            out_valid <= 1'b0;
            out_r     <= '0;
            out_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mm_a      <= head.a;
                        mm_b      <= head.b;
                        tag_q     <= head.tag;
                        mm_enable <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (mm_done) begin
                        out_r     <= mm_r;
                        out_tag   <= tag_q;
                        out_valid <= 1'b1;
                        mm_enable <= 1'b0;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
